// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: round-robin multi-requester transaction engine for the
// 8-bit Avalon SPI master core. A granted requester gets one atomic transfer
// of 1..MAXBYTES bytes to one slave. The sequence is:
//   slave-enable, SSO on, status clear, per-byte tx/poll/rx, TMT wait, SSO off.
//
// Handshake (req/gnt/done): a requester raises req and holds it, together
// with req_ss/req_len/req_wdata, until it sees its one-cycle done pulse. Its
// operands are sampled at grant. gnt stays high from ARB through DONE. rdata
// and err are valid while done is high.
//
// Core bus access: every access lasts three cycles. In phases 0 and 1,
// select, addr, data and one strobe are driven. Phase 2 is idle. Read data is
// captured on the edge that ends phase 1. The next-state decision is made at
// the end of phase 2.
module spi_txn_sequencer #(
   parameter int NREQ         = 2,
   parameter int MAXBYTES     = 4,
   parameter int POLL_TIMEOUT = 1023
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NREQ-1:0]              req,
   input  logic [3*NREQ-1:0]            req_ss,
   input  logic [2*NREQ-1:0]            req_len,
   input  logic [8*MAXBYTES*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]              gnt,
   output logic [NREQ-1:0]              done,
   output logic [8*MAXBYTES-1:0]        rdata,
   output logic                         err,
   output logic                         busy,
   output logic                         spi_select,
   output logic [2:0]                   mem_addr,
   output logic                         write_n,
   output logic                         read_n,
   output logic [15:0]                  data_from_cpu,
   input  logic [15:0]                  data_to_cpu,
   output logic [3:0]                   dbg_state
);

   localparam int DW  = 8 * MAXBYTES;
   localparam int BCW = (MAXBYTES > 1) ? $clog2(MAXBYTES) : 1;
   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PCW = $clog2(POLL_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_SEL, S_SSO_ON, S_CLR, S_TX,
      S_POLL_RX, S_RD, S_POLL_TMT, S_SSO_OFF, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        ph_q, ph_d;
   logic [PCW-1:0]    pcnt_q, pcnt_d;
   logic [BCW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [2:0]        ss_q, ss_d;
   logic [1:0]        len_q, len_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [15:0]       rd_q, rd_d;

   logic              win_found;
   logic [PW-1:0]     win_idx;
   logic [2:0]        win_ss;
   logic [1:0]        win_len;
   logic [DW-1:0]     win_wdata;
   int                idx_i;

   logic              acc_wr, acc_rd, acc_end;
   logic [2:0]        acc_addr;
   logic [15:0]       acc_data;

   // Round-robin pick: first asserted req at or after the pointer, and its operands.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx_i     = 0;
      win_ss    = '0;
      win_len   = '0;
      win_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_i = (int'(ptr_q) + k) % NREQ;
         if (!win_found && req[idx_i]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx_i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (32'(win_idx) == i) begin
            win_ss    = req_ss[3*i +: 3];
            win_len   = req_len[2*i +: 2];
            win_wdata = req_wdata[DW*i +: DW];
         end
      end
   end

   // Sequencer next-state, bus access generation and datapath updates.
   always_comb begin
      state_d  = state_q;
      ph_d     = ph_q;
      pcnt_d   = pcnt_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      ss_d     = ss_q;
      len_d    = len_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      rd_d     = rd_q;
      acc_wr   = 1'b0;
      acc_rd   = 1'b0;
      acc_addr = 3'd0;
      acc_data = 16'h0000;
      acc_end  = (ph_q == 2'd2);
      spi_select    = 1'b0;
      mem_addr      = 3'd0;
      write_n       = 1'b1;
      read_n        = 1'b1;
      data_from_cpu = 16'h0000;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               state_d = S_ARB;
               gnt_d   = NREQ'(1) << win_idx;
               ptr_d   = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
               ss_d    = win_ss;
               len_d   = win_len;
               wdata_d = win_wdata;
            end
         end
         S_ARB: begin
            rdata_d = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
            ph_d    = 2'd0;
            state_d = S_SEL;
         end
         S_SEL: begin
            acc_wr   = 1'b1;
            acc_addr = 3'd5;
            acc_data = 16'(1) << ss_q;
            if (acc_end) state_d = S_SSO_ON;
         end
         S_SSO_ON: begin
            acc_wr   = 1'b1;
            acc_addr = 3'd3;
            acc_data = 16'h0400;
            if (acc_end) state_d = S_CLR;
         end
         S_CLR: begin
            acc_wr   = 1'b1;
            acc_addr = 3'd2;
            if (acc_end) state_d = S_TX;
         end
         S_TX: begin
            acc_wr   = 1'b1;
            acc_addr = 3'd1;
            acc_data = {8'h00, wdata_q[DW-1 -: 8]};
            if (acc_end) begin
               state_d = S_POLL_RX;
               pcnt_d  = '0;
            end
         end
         S_POLL_RX, S_POLL_TMT: begin
            acc_rd   = 1'b1;
            acc_addr = 3'd2;
            if (acc_end) begin
               // Overrun flags mark the transfer bad but do not stop it.
               if (rd_q[5] || rd_q[4]) err_d = 1'b1;
               if ((state_q == S_POLL_RX) ? rd_q[8] : rd_q[6]) begin
                  state_d = (state_q == S_POLL_RX) ? S_RD : S_SSO_OFF;
               end else if (pcnt_q == PCW'(POLL_TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = S_SSO_OFF;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
         end
         S_RD: begin
            acc_rd   = 1'b1;
            acc_addr = 3'd0;
            if (acc_end) begin
               for (int i = 0; i < MAXBYTES; i++) begin
                  if (32'(cnt_q) == i) rdata_d[8*(MAXBYTES-1-i) +: 8] = rd_q[7:0];
               end
               if (32'(cnt_q) == 32'(len_q)) begin
                  state_d = S_POLL_TMT;
                  pcnt_d  = '0;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  wdata_d = wdata_q << 8;
                  state_d = S_TX;
               end
            end
         end
         S_SSO_OFF: begin
            acc_wr   = 1'b1;
            acc_addr = 3'd3;
            if (acc_end) state_d = S_DONE;
         end
         S_DONE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (acc_wr || acc_rd) begin
         ph_d = acc_end ? 2'd0 : ph_q + 2'd1;
         if (!acc_end) begin
            spi_select    = 1'b1;
            mem_addr      = acc_addr;
            data_from_cpu = acc_data;
            write_n       = !acc_wr;
            read_n        = !acc_rd;
         end
      end
      if (acc_rd && ph_q == 2'd1) rd_d = data_to_cpu;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         pcnt_q  <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         ss_q    <= '0;
         len_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         pcnt_q  <= pcnt_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         ss_q    <= ss_d;
         len_q   <= len_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = (state_q == S_DONE) ? gnt_q : '0;
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Bench for spi_txn_sequencer with a behavioural model of the SPI core.
// Expected core writes and completions are queued and then compared as the DUT produces them.
module tb_spi_txn_sequencer;
  localparam int NREQ = 2;
  localparam int MAXB = 4;
  localparam int PTO  = 7;

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req, gnt, done;
  logic [3*NREQ-1:0] req_ss;
  logic [2*NREQ-1:0] req_len;
  logic [8*MAXB*NREQ-1:0] req_wdata;
  logic [31:0] rdata;
  logic err, busy, spi_select, write_n, read_n;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic [3:0] dbg_state;

  spi_txn_sequencer #(.NREQ(NREQ), .MAXBYTES(MAXB), .POLL_TIMEOUT(PTO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_ss(req_ss), .req_len(req_len),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .busy(busy), .spi_select(spi_select), .mem_addr(mem_addr), .write_n(write_n),
    .read_n(read_n), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [18:0] exp_q[$];   // {addr, data} of expected core writes
  logic [34:0] res_q[$];   // {requester, err, rdata} of expected completions

  typedef struct {
    int          r;
    logic [2:0]  ss;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [7:0]  xr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // ---------------- SPI core model ----------------
  bit never_rrdy, toe_mode;
  logic [7:0] miso_xor;
  logic rrdy_m, tmt_m, toe_m;
  logic [7:0] rx_m, tx_m;
  int busy_m;
  logic wr_n_p, rd_n_p;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rrdy_m <= 1'b0; tmt_m <= 1'b1; toe_m <= 1'b0; rx_m <= 8'h00; tx_m <= 8'h00;
      busy_m <= 0; wr_n_p <= 1'b1; rd_n_p <= 1'b1; data_to_cpu <= 16'h0000;
    end else begin
      if (busy_m > 0) begin
        busy_m <= busy_m - 1;
        if (busy_m == 1) begin
          tmt_m <= 1'b1;
          rx_m  <= tx_m ^ miso_xor;
          if (!never_rrdy) rrdy_m <= 1'b1;
        end
      end
      if (spi_select && !write_n && wr_n_p) begin
        if (mem_addr == 3'd1) begin
          tx_m <= data_from_cpu[7:0]; busy_m <= 4; tmt_m <= 1'b0;
          if (toe_mode) toe_m <= 1'b1;
        end
        if (mem_addr == 3'd2) toe_m <= 1'b0;
      end
      if (spi_select && !read_n) begin
        if (mem_addr == 3'd0) begin
          data_to_cpu <= {8'h00, rx_m};
          if (rd_n_p) rrdy_m <= 1'b0;
        end
        if (mem_addr == 3'd2)
          data_to_cpu <= {7'b0, rrdy_m, 1'b0, tmt_m, toe_m, 1'b0, 4'b0};
      end
      wr_n_p <= write_n;
      rd_n_p <= read_n;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic m_wr_p = 1'b1, m_rd_p = 1'b1;
  int run = 0, stat_rd = 0, last_gap = 0, tx_wr_cnt = 0;
  logic [18:0] exp_w;
  logic [34:0] exp_r, act_r;

  always @(negedge clk) begin
    if (reset) begin
      m_wr_p = 1'b1; m_rd_p = 1'b1; run = 0; stat_rd = 0;
    end else begin
      if (!write_n || !read_n) run++;
      else begin
        if (run != 0) begin
          checks++;
          if (run != 2) begin failures++; $display("FAIL strobe_len actual=%0d required=2", run); end
        end
        run = 0;
      end
      if (!write_n && m_wr_p) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL write_unexpected actual=%0d:%h required=none", mem_addr, data_from_cpu);
        end else begin
          exp_w = exp_q.pop_front();
          if ({mem_addr, data_from_cpu} !== exp_w || !spi_select) begin
            failures++;
            $display("FAIL write actual=%0d:%h sel=%b required=%0d:%h", mem_addr, data_from_cpu, spi_select, exp_w[18:16], exp_w[15:0]);
          end
        end
        if (mem_addr == 3'd1) tx_wr_cnt++;
        last_gap = stat_rd;
        stat_rd = 0;
      end
      if (!read_n && m_rd_p && mem_addr == 3'd2) stat_rd++;
      if (|done) begin
        checks++;
        act_r = {done[1] ? 2'd1 : 2'd0, err, rdata};
        if (res_q.size() == 0) begin
          failures++; $display("FAIL done_unexpected actual=%h required=none", act_r);
        end else begin
          exp_r = res_q.pop_front();
          if (act_r !== exp_r || done !== gnt || $countones(done) != 1) begin
            failures++;
            $display("FAIL done actual=req%0d err=%b rdata=%h gnt=%b done=%b required=req%0d err=%b rdata=%h",
                     act_r[34:33], act_r[32], act_r[31:0], gnt, done, exp_r[34:33], exp_r[32], exp_r[31:0]);
          end
        end
      end
      m_wr_p = write_n;
      m_rd_p = read_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input vec_t v);
    logic [31:0] w;
    w = v.wdata;
    exp_q.push_back({3'd5, 16'(1) << v.ss});
    exp_q.push_back({3'd3, 16'h0400});
    exp_q.push_back({3'd2, 16'h0000});
    for (int i = 0; i <= int'(v.len); i++) begin
      exp_q.push_back({3'd1, 8'h00, w[31:24]});
      w = w << 8;
    end
    exp_q.push_back({3'd3, 16'h0000});
    res_q.push_back({2'(v.r), v.exp_err, v.exp_rdata});
  endtask

  task automatic load_req(input vec_t v);
    req_ss[3*v.r +: 3]   = v.ss;
    req_len[2*v.r +: 2]  = v.len;
    req_wdata[32*v.r +: 32] = v.wdata;
  endtask

  task automatic wait_done(input int r);
    bit got;
    got = 0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (done[r]) begin req[r] = 1'b0; got = 1; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done required=done%0d", r);
      req[r] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      failures++;
      $display("FAIL leftover actual=%0d/%0d required=0/0", exp_q.size(), res_q.size());
      exp_q.delete(); res_q.delete();
    end
  endtask

  task automatic do_txn(input vec_t v);
    miso_xor = v.xr;
    push_exp(v);
    load_req(v);
    req[v.r] = 1'b1;
    wait_done(v.r);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [59:0] act;
    checks++;
    act = {gnt, done, rdata, err, busy, spi_select, write_n, read_n, mem_addr, data_from_cpu};
    if (act !== {4'b0, 32'b0, 3'b000, 2'b11, 3'b000, 16'h0000}) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", tag, act, {4'b0, 32'b0, 3'b000, 2'b11, 3'b000, 16'h0000});
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  vec_t v, c0, c1;
  logic [1:0] cnt0, cnt1, raise;
  int ndone, base;

  initial begin
    vecs[0] = '{0, 3'd2, 2'd0, 32'hA5000000, 8'h00, 32'hA5000000, 1'b0};
    vecs[1] = '{0, 3'd5, 2'd3, 32'h01020304, 8'h00, 32'h01020304, 1'b0};
    vecs[2] = '{1, 3'd7, 2'd1, 32'hDEADBEEF, 8'h00, 32'hDEAD0000, 1'b0};
    vecs[3] = '{1, 3'd0, 2'd2, 32'h12345678, 8'h00, 32'h12345600, 1'b0};
    vecs[4] = '{0, 3'd3, 2'd3, 32'h11223344, 8'h0F, 32'h1E2D3C4B, 1'b0};
    vecs[5].r = int'($urandom_range(0, 1));
    vecs[5].ss = 3'($urandom_range(0, 7));
    vecs[5].len = 2'($urandom_range(0, 3));
    vecs[5].wdata = $urandom;
    vecs[5].xr = 8'h00;
    vecs[5].exp_rdata = vecs[5].wdata & ~(32'hFFFFFFFF >> (8 * (int'(vecs[5].len) + 1)));
    vecs[5].exp_err = 1'b0;

    never_rrdy = 0; toe_mode = 0; miso_xor = 8'h00;
    req = '0; req_ss = '0; req_len = '0; req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");

    // table-driven single transfers
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // reset during the second TX access
    v = '{0, 3'd6, 2'd3, 32'h0BADCAFE, 8'h00, 32'h0BADCAFE, 1'b0};
    push_exp(v); load_req(v);
    base = tx_wr_cnt;
    req[0] = 1'b1;
    for (int n = 0; n < 500 && tx_wr_cnt < base + 2; n++) @(negedge clk);
    checks++;
    if (tx_wr_cnt < base + 2) begin
      failures++; $display("FAIL second_tx_seen actual=%0d required=%0d", tx_wr_cnt - base, 2);
    end
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check_reset_outputs("reset_mid_txn");
    exp_q.delete(); res_q.delete();
    reset = 1'b0;
    @(negedge clk);
    do_txn('{1, 3'd4, 2'd1, 32'h6789ABCD, 8'h00, 32'h67890000, 1'b0});

    // two requesters contending twice; pointer restarts at 0 after reset
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    c0 = '{0, 3'd1, 2'd1, 32'hC0FFEE00, 8'h00, 32'hC0FF0000, 1'b0};
    c1 = '{1, 3'd6, 2'd0, 32'h5A5A1234, 8'h00, 32'h5A000000, 1'b0};
    push_exp(c0); push_exp(c1); push_exp(c0); push_exp(c1);
    load_req(c0); load_req(c1);
    cnt0 = 0; cnt1 = 0; raise = 0; ndone = 0;
    req = 2'b11;
    for (int n = 0; n < 5000 && ndone < 4; n++) begin
      @(negedge clk);
      req = req | raise;
      raise = 0;
      if (done[0]) begin cnt0++; ndone++; req[0] = 1'b0; raise[0] = (cnt0 < 2); end
      if (done[1]) begin cnt1++; ndone++; req[1] = 1'b0; raise[1] = (cnt1 < 2); end
    end
    checks++;
    if (ndone != 4) begin
      failures++; $display("FAIL contention_dones actual=%0d required=4", ndone);
    end
    req = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      failures++; $display("FAIL contention_leftover actual=%0d/%0d required=0/0", exp_q.size(), res_q.size());
      exp_q.delete(); res_q.delete();
    end

    // RRDY never arrives: PTO+1 status reads, then SSO release with err
    never_rrdy = 1;
    do_txn('{0, 3'd4, 2'd0, 32'h77000000, 8'h00, 32'h00000000, 1'b1});
    checks++;
    if (last_gap != PTO + 1) begin
      failures++; $display("FAIL timeout_polls actual=%0d required=%0d", last_gap, PTO + 1);
    end
    never_rrdy = 0;

    // TOE during polling: full data, err set
    toe_mode = 1;
    do_txn('{1, 3'd1, 2'd1, 32'hABCD0000, 8'h00, 32'hABCD0000, 1'b1});
    toe_mode = 0;

    // clean transfer after the error cases
    do_txn('{0, 3'd2, 2'd0, 32'h3C000000, 8'h00, 32'h3C000000, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
